// File: rtl/node_pkg.sv
// Shared definitions for the layer sequencer: datapath width, FSM states and
// helpers for flat weight addressing and counter sizing.
package node_pkg;

  localparam int W = 10;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_EMIT    = 2'd2
  } state_t;

  function automatic int weight_addr(input int neuron, input int idx, input int n_in);
    return neuron * n_in + idx;
  endfunction

  // Counter/address width that never collapses to zero bits.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/node_weight_mem.sv
// Layer weight register file: one synchronous write port and two combinational
// read ports feeding the even/odd weight operands of a node pair.
module node_weight_mem #(
  parameter int W     = node_pkg::W,
  parameter int DEPTH = 12,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr_even,
  input  logic [AW-1:0] rd_addr_odd,
  output logic [W-1:0]  rd_data_even,
  output logic [W-1:0]  rd_data_odd
);

  logic [W-1:0] mem [DEPTH];

  // Addresses past the last weight are silently ignored.
  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_even = (int'(rd_addr_even) < DEPTH) ? mem[rd_addr_even] : '0;
  assign rd_data_odd  = (int'(rd_addr_odd)  < DEPTH) ? mem[rd_addr_odd]  : '0;

endmodule

// File: rtl/node_sequencer.sv
// Time-multiplexes one external combinational node across a fully connected
// layer: buffers features, walks neurons and input pairs, emits one sum per neuron.
module node_sequencer #(
  parameter int W     = node_pkg::W,
  parameter int N_IN  = 4,
  parameter int N_OUT = 3,
  localparam int AW   = node_pkg::clog2_min1(N_OUT * N_IN),
  localparam int IW   = node_pkg::clog2_min1(N_OUT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  output logic [W-1:0]  node_a,
  output logic [W-1:0]  node_b,
  output logic [W-1:0]  node_multa,
  output logic [W-1:0]  node_multb,
  input  logic [W-1:0]  node_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [IW-1:0] out_idx,
  output logic          busy
);

  import node_pkg::*;

  localparam int LW = clog2_min1(N_IN);
  localparam int PW = clog2_min1(N_IN / 2);

  state_t        state;
  logic [LW-1:0] load_cnt;
  logic [IW-1:0] neuron;
  logic [PW-1:0] pair;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_next;
  logic [W-1:0]  feat [N_IN];

  logic [LW-1:0] ev_idx;
  logic [LW-1:0] od_idx;
  logic [AW-1:0] wa_even;
  logic [AW-1:0] wa_odd;
  logic [W-1:0]  w_even;
  logic [W-1:0]  w_odd;

  assign in_ready = (state == ST_LOAD);
  assign busy     = (state != ST_LOAD);

  assign ev_idx   = LW'({pair, 1'b0});
  assign od_idx   = ev_idx + LW'(1);
  assign wa_even  = AW'(weight_addr(int'(neuron), int'(ev_idx), N_IN));
  assign wa_odd   = AW'(weight_addr(int'(neuron), int'(od_idx), N_IN));
  assign acc_next = acc + node_result;

  // Weights may only change between layers, so writes are gated to LOAD.
  node_weight_mem #(
    .W     (W),
    .DEPTH (N_OUT * N_IN),
    .AW    (AW)
  ) u_wmem (
    .clk          (clk),
    .wr_en        (wr_en && (state == ST_LOAD)),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_addr_even (wa_even),
    .rd_addr_odd  (wa_odd),
    .rd_data_even (w_even),
    .rd_data_odd  (w_odd)
  );

  always_ff @(posedge clk) begin
    if (!rst && (state == ST_LOAD) && in_valid) begin
      feat[load_cnt] <= in_data;
    end
  end

  // Operands are quiet outside COMPUTE so the shared node does not toggle.
  always_comb begin
    node_a     = '0;
    node_b     = '0;
    node_multa = '0;
    node_multb = '0;
    if (state == ST_COMPUTE) begin
      node_a     = feat[ev_idx];
      node_b     = feat[od_idx];
      node_multa = w_even;
      node_multb = w_odd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      load_cnt  <= '0;
      neuron    <= '0;
      pair      <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_valid) begin
            if (load_cnt == LW'(N_IN - 1)) begin
              load_cnt <= '0;
              neuron   <= '0;
              pair     <= '0;
              acc      <= '0;
              state    <= ST_COMPUTE;
            end else begin
              load_cnt <= load_cnt + LW'(1);
            end
          end
        end
        ST_COMPUTE: begin
          acc <= acc_next;
          if (pair == PW'(N_IN / 2 - 1)) begin
            out_data  <= acc_next;
            out_idx   <= neuron;
            out_valid <= 1'b1;
            state     <= ST_EMIT;
          end else begin
            pair <= pair + PW'(1);
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (neuron == IW'(N_OUT - 1)) begin
              state <= ST_LOAD;
            end else begin
              neuron <= neuron + IW'(1);
              pair   <= '0;
              acc    <= '0;
              state  <= ST_COMPUTE;
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_node_sequencer.sv
// Bench for node_sequencer: a dot-product layer model checked every cycle,
// directed literal cases, then randomized traffic.
`timescale 1ns/1ps
module tb_node_sequencer;

  localparam int W     = 10;
  localparam int N_IN  = 4;
  localparam int N_OUT = 3;
  localparam int NW    = N_IN * N_OUT;
  localparam int AW    = 4;
  localparam int IW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  node_a, node_b, node_multa, node_multb, node_result;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_idx;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // The external node: A*multA + B*multB, truncated to W bits.
  assign node_result = W'(32'(node_a) * 32'(node_multa) + 32'(node_b) * 32'(node_multb));

  node_sequencer #(.W(W), .N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .node_a(node_a), .node_b(node_b), .node_multa(node_multa), .node_multb(node_multb),
    .node_result(node_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .busy(busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Layer model: feature buffer, weight table, and the cycle budget of each phase.
  bit m_on = 1'b0;
  bit m_load, m_valid;
  int m_cnt, m_n, m_wait, m_data, m_idx;
  int mf [N_IN];
  int mw [NW];

  function automatic int dotProduct(input int n);
    int s;
    s = 0;
    for (int i = 0; i < N_IN; i++) s += mf[i] * mw[n * N_IN + i];
    return s % (1 << W);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1'b1; m_load = 1'b1; m_valid = 1'b0;
      m_cnt = 0; m_n = 0; m_wait = 0; m_data = 0; m_idx = 0;
    end else if (m_on) begin
      if (m_load) begin
        if (wr_en && int'(wr_addr) < NW) mw[wr_addr] = int'(wr_data);
        if (in_valid) begin
          mf[m_cnt] = int'(in_data);
          m_cnt++;
          if (m_cnt == N_IN) begin
            m_load = 1'b0; m_cnt = 0; m_n = 0; m_wait = N_IN / 2;
          end
        end
      end else if (m_valid) begin
        if (out_ready) begin
          m_valid = 1'b0;
          if (m_n == N_OUT - 1) m_load = 1'b1;
          else begin m_n++; m_wait = N_IN / 2; end
        end
      end else begin
        m_wait--;
        if (m_wait == 0) begin
          m_valid = 1'b1; m_data = dotProduct(m_n); m_idx = m_n;
        end
      end
    end
  end

  bit cmp_computing;
  int cmp_p;
  int e_a, e_b, e_ma, e_mb;

  always @(negedge clk) begin
    if (m_on) begin
      cmp_computing = !m_load && !m_valid;
      cmp_p = N_IN / 2 - m_wait;
      e_a = 0; e_b = 0; e_ma = 0; e_mb = 0;
      if (cmp_computing) begin
        e_a  = mf[2 * cmp_p];
        e_b  = mf[2 * cmp_p + 1];
        e_ma = mw[m_n * N_IN + 2 * cmp_p];
        e_mb = mw[m_n * N_IN + 2 * cmp_p + 1];
      end
      checkOutput("in_ready",   32'(in_ready),   32'(m_load));
      checkOutput("busy",       32'(busy),       32'(!m_load));
      checkOutput("out_valid",  32'(out_valid),  32'(m_valid));
      checkOutput("out_data",   32'(out_data),   m_data);
      checkOutput("out_idx",    32'(out_idx),    m_idx);
      checkOutput("node_a",     32'(node_a),     e_a);
      checkOutput("node_b",     32'(node_b),     e_b);
      checkOutput("node_multa", 32'(node_multa), e_ma);
      checkOutput("node_multb", 32'(node_multb), e_mb);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeWeight(input int addr, input int data);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_data = W'(data);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic applyStimulus(input int f0, input int f1, input int f2, input int f3);
    int f [N_IN];
    int guard;
    logic took;
    f[0] = f0; f[1] = f1; f[2] = f2; f[3] = f3;
    for (int i = 0; i < N_IN; i++) begin
      guard = 0; took = 1'b0;
      in_valid = 1'b1; in_data = W'(f[i]);
      while (!took && guard < 50) begin
        took = in_ready;
        tick();
        guard++;
      end
      if (!took) checkOutput("load_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic waitResult(input int exp_idx, input int exp_data, input string tag);
    int guard;
    guard = 0;
    while (out_valid !== 1'b1 && guard < 40) begin tick(); guard++; end
    if (out_valid !== 1'b1) checkOutput({tag, "_timeout"}, 0, 1);
    else begin
      checkOutput({tag, "_data"},  32'(out_data), exp_data);
      checkOutput({tag, "_idx"},   32'(out_idx),  exp_idx);
      checkOutput({tag, "_model"}, m_data,        exp_data);
      if (out_ready) tick();
    end
  endtask

  task automatic writeNeuron(input int n, input int w0, input int w1, input int w2, input int w3);
    writeWeight(n * N_IN + 0, w0);
    writeWeight(n * N_IN + 1, w1);
    writeWeight(n * N_IN + 2, w2);
    writeWeight(n * N_IN + 3, w3);
  endtask

  initial begin
    #500us;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc_cnt;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checkOutput("rst_in_ready",  32'(in_ready),  1);
    checkOutput("rst_busy",      32'(busy),      0);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_data",  32'(out_data),  0);
    checkOutput("rst_out_idx",   32'(out_idx),   0);

    writeNeuron(0, 1, 2, 3, 4);
    writeNeuron(1, 1, 1, 1, 1);
    writeNeuron(2, 2, 0, 0, 1);
    writeWeight(13, 77);

    // Basic layer and result timing
    applyStimulus(5, 6, 7, 8);
    checkOutput("t1_busy", 32'(busy), 1);
    checkOutput("t1_early_valid", 32'(out_valid), 0);
    tick();
    checkOutput("t1_mid_valid", 32'(out_valid), 0);
    tick();
    checkOutput("t1_rise_valid", 32'(out_valid), 1);
    waitResult(0, 70, "t1_n0");
    waitResult(1, 26, "t1_n1");
    waitResult(2, 18, "t1_n2");

    // Backpressure plus a weight write while busy
    out_ready = 1'b0;
    applyStimulus(5, 6, 7, 8);
    writeWeight(0, 9);
    waitResult(0, 70, "t3_n0");
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("t3_hold_data",  32'(out_data),   70);
      checkOutput("t3_hold_idx",   32'(out_idx),    0);
      checkOutput("t3_hold_valid", 32'(out_valid),  1);
      checkOutput("t3_hold_busy",  32'(busy),       1);
      checkOutput("t3_hold_a",     32'(node_a),     0);
      checkOutput("t3_hold_ma",    32'(node_multa), 0);
    end
    out_ready = 1'b1;
    tick();
    checkOutput("t3_next_valid", 32'(out_valid),  0);
    checkOutput("t3_next_a",     32'(node_a),     5);
    checkOutput("t3_next_b",     32'(node_b),     6);
    checkOutput("t3_next_ma",    32'(node_multa), 1);
    waitResult(1, 26, "t3_n1");
    waitResult(2, 18, "t3_n2");

    applyStimulus(5, 6, 7, 8);
    waitResult(0, 70, "t4_old_n0");
    waitResult(1, 26, "t4_old_n1");
    waitResult(2, 18, "t4_old_n2");
    writeWeight(0, 9);
    applyStimulus(5, 6, 7, 8);
    waitResult(0, 110, "t4_new_n0");
    waitResult(1, 26, "t4_new_n1");
    waitResult(2, 18, "t4_new_n2");

    // Modulo-2^W wraparound
    writeNeuron(0, 2, 0, 0, 0);
    applyStimulus(600, 1, 1, 1);
    waitResult(0, 176, "t2a_n0");
    waitResult(1, 603, "t2a_n1");
    waitResult(2, 177, "t2a_n2");
    writeNeuron(0, 1, 1, 1, 1);
    applyStimulus(1023, 1023, 1023, 1023);
    waitResult(0, 1020, "t2b_n0");
    waitResult(1, 1020, "t2b_n1");
    waitResult(2, 1021, "t2b_n2");

    // Reset on the second COMPUTE cycle
    applyStimulus(5, 6, 7, 8);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t5_busy",      32'(busy),      0);
    checkOutput("t5_out_valid", 32'(out_valid), 0);
    checkOutput("t5_in_ready",  32'(in_ready),  1);
    checkOutput("t5_out_data",  32'(out_data),  0);
    applyStimulus(1, 2, 3, 4);
    waitResult(0, 10, "t5_n0");
    waitResult(1, 10, "t5_n1");
    waitResult(2, 6,  "t5_n2");

    // in_valid held for six words; only four are consumed
    writeNeuron(0, 1, 2, 3, 4);
    acc_cnt = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = W'(10 + i);
      if (in_ready) acc_cnt++;
      tick();
    end
    in_valid = 1'b0;
    checkOutput("t6_accepted", acc_cnt, 4);
    checkOutput("t6_in_ready", 32'(in_ready), 0);
    waitResult(0, 120, "t6_n0");
    waitResult(1, 46,  "t6_n1");
    waitResult(2, 33,  "t6_n2");

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      in_data   = W'($urandom);
      wr_en     = ($urandom_range(0, 3) == 0);
      wr_addr   = AW'($urandom);
      wr_data   = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; wr_en = 1'b0; out_ready = 1'b1;
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
